// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for one N_IN-input gate: drives every vector, settles, samples, scores.
// Optional macro TT_SWEEP_ABORT_EN adds an abort input that cancels a sweep in progress.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef TT_SWEEP_ABORT_EN
  input  logic                 abort,
`endif
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt
);

  localparam int unsigned N_VEC = 2**N_IN;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN:0]  LAST_IDX   = (N_IN+1)'(N_VEC - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    dut_in_q, dut_in_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [N_VEC-1:0]   table_q, table_d;
  logic [N_VEC-1:0]   exp_q, exp_d;
  logic [N_IN:0]      mismatch_cnt_q, mismatch_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               abort_hit;

  // Next-state and next-output logic; abort overrides everything while busy.
  always_comb begin
    state_d        = state_q;
    dut_in_d       = dut_in_q;
    settle_cnt_d   = settle_cnt_q;
    table_d        = table_q;
    exp_d          = exp_q;
    mismatch_cnt_d = mismatch_cnt_q;
    busy_d         = busy_q;
    done_d         = done_q;
    pass_d         = pass_q;
    abort_hit      = 1'b0;
`ifdef TT_SWEEP_ABORT_EN
    abort_hit      = abort && (state_q == S_SETTLE || state_q == S_SAMPLE);
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d        = S_SETTLE;
          dut_in_d       = '0;
          settle_cnt_d   = '0;
          table_d        = '0;
          mismatch_cnt_d = '0;
          exp_d          = expected;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          pass_d         = 1'b0;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_END) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        table_d[dut_in_q] = dut_out;
        if (dut_out != exp_q[dut_in_q]) begin
          mismatch_cnt_d = mismatch_cnt_q + (N_IN+1)'(1);
        end
        // Terminal compare is one bit wider so N_IN=8 cannot wrap.
        if ({1'b0, dut_in_q} == LAST_IDX) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mismatch_cnt_d == '0);
        end else begin
          state_d      = S_SETTLE;
          dut_in_d     = dut_in_q + N_IN'(1);
          settle_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_hit) begin
      state_d        = S_IDLE;
      dut_in_d       = '0;
      settle_cnt_d   = '0;
      table_d        = table_q;
      mismatch_cnt_d = mismatch_cnt_q;
      busy_d         = 1'b0;
      done_d         = 1'b0;
      pass_d         = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      dut_in_q       <= '0;
      settle_cnt_q   <= '0;
      table_q        <= '0;
      exp_q          <= '0;
      mismatch_cnt_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      dut_in_q       <= dut_in_d;
      settle_cnt_q   <= settle_cnt_d;
      table_q        <= table_d;
      exp_q          <= exp_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
    end
  end

  assign dut_in       = dut_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mismatch_cnt_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: XNOR gate at N_IN=2/SETTLE=3 and parity gate at N_IN=3/SETTLE=1.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 2-input XNOR, SETTLE=3
  logic       a_start, a_abort;
  logic [3:0] a_exp, a_tab;
  logic [1:0] a_in;
  logic       a_out, a_busy, a_done, a_pass;
  logic [2:0] a_mc;
  assign a_out = ~(a_in[1] ^ a_in[0]);

  // Instance B: 3-input parity, SETTLE=1
  logic       b_start, b_abort;
  logic [7:0] b_exp, b_tab;
  logic [2:0] b_in;
  logic       b_out, b_busy, b_done, b_pass;
  logic [3:0] b_mc;
  assign b_out = ^b_in;

  truth_table_sweeper #(.N_IN(2), .SETTLE(3)) u_a (
    .clk(clk), .rst(rst), .start(a_start),
`ifdef TT_SWEEP_ABORT_EN
    .abort(a_abort),
`endif
    .expected(a_exp), .dut_in(a_in), .dut_out(a_out), .busy(a_busy), .done(a_done),
    .table_out(a_tab), .pass(a_pass), .mismatch_cnt(a_mc)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start),
`ifdef TT_SWEEP_ABORT_EN
    .abort(b_abort),
`endif
    .expected(b_exp), .dut_in(b_in), .dut_out(b_out), .busy(b_busy), .done(b_done),
    .table_out(b_tab), .pass(b_pass), .mismatch_cnt(b_mc)
  );

  typedef struct {
    logic [7:0] tab;
    logic       pass;
    logic [3:0] mc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: gate function applied to every vector, scored against the expected table.
  function automatic exp_t model(input int n_in, input bit is_parity, input logic [7:0] exp_tab);
    exp_t r;
    r.tab = '0;
    r.mc  = '0;
    for (int k = 0; k < (1 << n_in); k++) begin
      logic [2:0] v;
      logic       g;
      v = 3'(k);
      g = is_parity ? ^v : ~(v[1] ^ v[0]);
      r.tab[k] = g;
      if (g != exp_tab[k]) r.mc = r.mc + 4'd1;
    end
    r.pass = (r.mc == 4'd0);
    return r;
  endfunction

  task automatic compare_pop(input string tag, input logic [7:0] tab, input logic pass,
                             input logic [3:0] mc);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_table"}, 32'(tab), 32'(e.tab));
    check({tag, "_pass"},  32'(pass), 32'(e.pass));
    check({tag, "_mcnt"},  32'(mc), 32'(e.mc));
  endtask

  // Full sweep on A; optionally pulses start and scrambles expected mid-sweep.
  task automatic sweep_a(input string tag, input logic [3:0] exp_tab, input bit disturb);
    a_exp   = exp_tab;
    a_start = 1'b1;
    sb_q.push_back(model(2, 1'b0, {4'b0, exp_tab}));
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check({tag, "_dut_in"}, 32'(a_in), 32'(i / 4));
      check({tag, "_busy"}, 32'(a_busy), 32'd1);
      check({tag, "_done_early"}, 32'(a_done), 32'd0);
      if (disturb && i == 5) begin
        a_start = 1'b1;
        a_exp   = ~exp_tab;
      end
      @(posedge clk); #1;
      a_start = 1'b0;
    end
    check({tag, "_done"}, 32'(a_done), 32'd1);
    check({tag, "_busy_end"}, 32'(a_busy), 32'd0);
    check({tag, "_dut_in_hold"}, 32'(a_in), 32'd3);
    compare_pop(tag, {4'b0, a_tab}, a_pass, {1'b0, a_mc});
    @(posedge clk); #1;
    check({tag, "_done_stays"}, 32'(a_done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_exp = '0;
    b_start = 1'b0; b_abort = 1'b0; b_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_outputs", {24'b0, a_in, a_busy, a_done, a_tab}, 32'd0);
    check("rst_a_pass_mc", {28'b0, a_pass, a_mc}, 32'd0);
    check("rst_b_outputs", {16'b0, b_in, b_busy, b_done, b_tab, b_mc}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    sweep_a("xnor_match", 4'b1001, 1'b0);
    sweep_a("xnor_one_miss", 4'b1000, 1'b0);
    sweep_a("xnor_restart_ignored", 4'b1001, 1'b1);
    sweep_a("xnor_all_miss", 4'b0110, 1'b0);

    // Reset mid-sweep: outputs clear without a clock edge, then a fresh sweep completes.
    a_exp = 4'b1001; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("midrst_busy_before", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {24'b0, a_in, a_busy, a_done, a_tab}, 32'd0);
    check("midrst_pass_mc", {28'b0, a_pass, a_mc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    sweep_a("after_rst", 4'b1001, 1'b0);

    // Parity gate, N_IN=3, SETTLE=1: two edges per vector.
    b_exp = 8'b1001_0110; b_start = 1'b1;
    sb_q.push_back(model(3, 1'b1, 8'b1001_0110));
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("par_dut_in", 32'(b_in), 32'(i / 2));
      check("par_done_early", 32'(b_done), 32'd0);
      @(posedge clk); #1;
    end
    check("par_done", 32'(b_done), 32'd1);
    compare_pop("par", b_tab, b_pass, b_mc);

`ifdef TT_SWEEP_ABORT_EN
    a_exp = 4'b1001; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_done", 32'(a_done), 32'd0);
    check("abort_pass", 32'(a_pass), 32'd0);
    check("abort_dut_in", 32'(a_in), 32'd0);
    check("abort_table", 32'(a_tab), 32'b0001);
    check("abort_mcnt", 32'(a_mc), 32'd0);
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    check("abort_idle_ignored", 32'(a_tab), 32'b0001);
`endif

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
